// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle load/store responder with wait states and big-endian byte lanes
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  output logic        ReqReady,
  output logic        RespValid,
  output logic [31:0] RespRData,
  output logic        RespErr,
  output logic        Busy
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic                    signed_q, signed_d;
  logic [1:0]              size_q, size_d;
  logic [1:0]              off_q, off_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;

  logic [31:0]             mem [DEPTH];

  logic                    is_word, is_half, misalign, commit;
  logic [31:0]             rword, load_data, wword;
  logic [7:0]              rbyte;
  logic [15:0]             rhalf;
  logic [3:0]              wmask;

  // Address bits above the word index wrap the memory and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^ReqAddr[31:ADDR_WIDTH+2];

  // Next-state logic: latch the request on accept, count wait states, single ACCESS cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    signed_d = signed_q;
    size_d   = size_q;
    off_d    = off_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    ReqReady = 1'b0;
    case (state_q)
      S_IDLE: begin
        ReqReady = !Reset;
        if (ReqValid && !Reset) begin
          write_d  = ReqWrite;
          signed_d = ReqSigned;
          size_d   = ReqSize;
          off_d    = ReqAddr[1:0];
          idx_d    = ReqAddr[ADDR_WIDTH+1:2];
          wdata_d  = ReqWData;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: alignment check, big-endian lane select for loads, lane mask for stores, outputs.
  always_comb begin
    is_word  = (size_q == 2'b00) || (size_q == 2'b11);
    is_half  = (size_q == 2'b01);
    misalign = (is_word && (off_q != 2'b00)) || (is_half && off_q[0]);
    rword    = mem[idx_q];
    case (off_q)
      2'd0:    rbyte = rword[31:24];
      2'd1:    rbyte = rword[23:16];
      2'd2:    rbyte = rword[15:8];
      default: rbyte = rword[7:0];
    endcase
    rhalf = off_q[1] ? rword[15:0] : rword[31:16];
    if (is_word) begin
      load_data = rword;
      wword     = wdata_q;
      wmask     = 4'b1111;
    end else if (is_half) begin
      load_data = signed_q ? {{16{rhalf[15]}}, rhalf} : {16'h0000, rhalf};
      wword     = {2{wdata_q[15:0]}};
      wmask     = off_q[1] ? 4'b0011 : 4'b1100;
    end else begin
      load_data = signed_q ? {{24{rbyte[7]}}, rbyte} : {24'h000000, rbyte};
      wword     = {4{wdata_q[7:0]}};
      wmask     = 4'b1000 >> off_q;
    end
    RespValid = !Reset && (state_q == S_ACCESS);
    Busy      = !Reset && (state_q != S_IDLE);
    RespErr   = RespValid && misalign;
    RespRData = (RespValid && !write_q && !misalign) ? load_data : 32'h0000_0000;
    commit    = !Reset && (state_q == S_ACCESS) && write_q && !misalign;
  end

  // State and latched-request registers; reset abandons any outstanding access.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      off_q    <= 2'b00;
      idx_q    <= '0;
      wdata_q  <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      signed_q <= signed_d;
      size_q   <= size_d;
      off_q    <= off_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
    end
  end

  // Store commit at the edge ending ACCESS; only selected byte lanes change.
  always_ff @(posedge Clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) begin
          mem[idx_q][8*b +: 8] <= wword[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [1:0]  req_size   [2];
  logic        req_signed [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        busy       [2];

  int n_checks = 0;
  int n_errors = 0;

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
    .Clk(clk), .Reset(rst), .ReqValid(req_valid[0]), .ReqWrite(req_write[0]),
    .ReqAddr(req_addr[0]), .ReqWData(req_wdata[0]), .ReqSize(req_size[0]),
    .ReqSigned(req_signed[0]), .ReqReady(req_ready[0]), .RespValid(resp_valid[0]),
    .RespRData(resp_rdata[0]), .RespErr(resp_err[0]), .Busy(busy[0])
  );

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .Clk(clk), .Reset(rst), .ReqValid(req_valid[1]), .ReqWrite(req_write[1]),
    .ReqAddr(req_addr[1]), .ReqWData(req_wdata[1]), .ReqSize(req_size[1]),
    .ReqSigned(req_signed[1]), .ReqReady(req_ready[1]), .RespValid(resp_valid[1]),
    .RespRData(resp_rdata[1]), .RespErr(resp_err[1]), .Busy(busy[1])
  );

  always #5 clk = ~clk;

  // Reference model: byte-addressed big-endian memory plus one pending-access record per instance.
  int          ws [2] = '{2, 0};
  int          cyc = 0;
  bit          started = 1'b0;
  bit [7:0]    mb [2][4096];
  bit          pend  [2];
  int          due   [2];
  bit          p_wr  [2];
  bit          p_err [2];
  logic [31:0] p_rd  [2];
  logic [31:0] p_wd  [2];
  int          p_a   [2];
  logic [1:0]  p_sz  [2];

  always @(posedge clk) begin
    int          a;
    bit          was, mis;
    logic [31:0] rd, wd;
    logic [15:0] h;
    logic [7:0]  b;
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      was = pend[i];
      if (rst) begin
        pend[i] = 1'b0;
        started = 1'b1;
      end else begin
        if (pend[i] && cyc == due[i] + 1) begin
          if (p_wr[i] && !p_err[i]) begin
            a  = p_a[i];
            wd = p_wd[i];
            case (p_sz[i])
              2'd1: begin mb[i][a] = wd[15:8]; mb[i][a+1] = wd[7:0]; end
              2'd2: mb[i][a] = wd[7:0];
              default: for (int k = 0; k < 4; k++) mb[i][a+k] = wd[31-8*k -: 8];
            endcase
          end
          pend[i] = 1'b0;
        end
        if (started && !was && req_valid[i]) begin
          a   = int'(req_addr[i][11:0]);
          mis = ((req_size[i] == 2'd0 || req_size[i] == 2'd3) && (a % 4 != 0)) ||
                (req_size[i] == 2'd1 && (a % 2 != 0));
          rd  = 32'h0;
          if (!req_write[i] && !mis) begin
            case (req_size[i])
              2'd1: begin
                h  = {mb[i][a], mb[i][a+1]};
                rd = req_signed[i] ? {{16{h[15]}}, h} : {16'h0, h};
              end
              2'd2: begin
                b  = mb[i][a];
                rd = req_signed[i] ? {{24{b[7]}}, b} : {24'h0, b};
              end
              default: rd = {mb[i][a], mb[i][a+1], mb[i][a+2], mb[i][a+3]};
            endcase
          end
          pend[i]  = 1'b1;
          due[i]   = cyc + ws[i];
          p_wr[i]  = req_write[i];
          p_err[i] = mis;
          p_rd[i]  = rd;
          p_wd[i]  = req_wdata[i];
          p_a[i]   = a;
          p_sz[i]  = req_size[i];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    bit          ev, er;
    logic [31:0] erd;
    #1;
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        ev  = !rst && pend[i] && (cyc == due[i]);
        er  = ev && p_err[i];
        erd = ev ? p_rd[i] : 32'h0;
        chk($sformatf("inst%0d cyc%0d ready", i, cyc), 32'(req_ready[i]), 32'(!rst && !pend[i]));
        chk($sformatf("inst%0d cyc%0d busy", i, cyc), 32'(busy[i]), 32'(!rst && pend[i]));
        chk($sformatf("inst%0d cyc%0d valid", i, cyc), 32'(resp_valid[i]), 32'(ev));
        chk($sformatf("inst%0d cyc%0d err", i, cyc), 32'(resp_err[i]), 32'(er));
        chk($sformatf("inst%0d cyc%0d rdata", i, cyc), resp_rdata[i], erd);
      end
    end
  end

  // One request: wait for ready, accept, scramble inputs, then time the response.
  task automatic do_req(input int i, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic sgn,
                        output logic [31:0] rd, output logic er, output int lat, output int bc);
    int n;
    bit got;
    @(negedge clk);
    req_write[i] = wr; req_addr[i] = addr; req_wdata[i] = wdata;
    req_size[i] = size; req_signed[i] = sgn; req_valid[i] = 1'b1;
    n = 0;
    while (!req_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(req_ready[i]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'b0; req_write[i] = ~wr; req_addr[i] = ~addr;
    req_wdata[i] = ~wdata; req_size[i] = ~size; req_signed[i] = ~sgn;
    lat = 0; bc = 0; rd = 32'h0; er = 1'b0; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (k > 0) @(negedge clk);
      lat++;
      if (busy[i]) bc++;
      if (resp_valid[i]) begin
        rd = resp_rdata[i];
        er = resp_err[i];
        got = 1'b1;
      end
    end
    if (!got) chk("resp_timeout", 32'(got), 32'd1);
  endtask

  logic [31:0] exp_s [4] = '{32'hFFFFFFDE, 32'hFFFFFFAD, 32'hFFFFFFBE, 32'hFFFFFFEF};
  logic [31:0] exp_u [4] = '{32'h000000DE, 32'h000000AD, 32'h000000BE, 32'h000000EF};

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, bc, na, nr, last_a, last_r;
    bit          sawv;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 32'h0;
      req_wdata[i] = 32'h0; req_size[i] = 2'b00; req_signed[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("ready_in_reset", 32'(req_ready[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready[0]), 32'd1);
    chk("valid_after_reset", 32'(resp_valid[0]), 32'd0);

    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0, rd, er, lat, bc);
    chk("st_latency", lat, 3); chk("st_busy_cycles", bc, 3); chk("st_err", 32'(er), 0);
    do_req(0, 1'b0, 32'h10, 32'h0, 2'b00, 1'b0, rd, er, lat, bc);
    chk("ld_word", rd, 32'hDEADBEEF); chk("ld_latency", lat, 3); chk("ld_busy_cycles", bc, 3);
    chk("ld_err", 32'(er), 0);

    for (int k = 0; k < 4; k++) begin
      do_req(0, 1'b0, 32'h10 + k, 32'h0, 2'b10, 1'b1, rd, er, lat, bc);
      chk($sformatf("ld_byte_s%0d", k), rd, exp_s[k]);
      do_req(0, 1'b0, 32'h10 + k, 32'h0, 2'b10, 1'b0, rd, er, lat, bc);
      chk($sformatf("ld_byte_u%0d", k), rd, exp_u[k]);
    end

    do_req(0, 1'b1, 32'h12, 32'hFFFF1234, 2'b01, 1'b0, rd, er, lat, bc);
    do_req(0, 1'b0, 32'h10, 32'h0, 2'b00, 1'b0, rd, er, lat, bc);
    chk("ld_after_half_st", rd, 32'hDEAD1234);
    do_req(0, 1'b0, 32'h10, 32'h0, 2'b01, 1'b1, rd, er, lat, bc);
    chk("ld_half_s", rd, 32'hFFFFDEAD);
    do_req(0, 1'b0, 32'h12, 32'h0, 2'b01, 1'b0, rd, er, lat, bc);
    chk("ld_half_u", rd, 32'h00001234);

    do_req(0, 1'b1, 32'h11, 32'hCAFEF00D, 2'b00, 1'b0, rd, er, lat, bc);
    chk("mis_st_err", 32'(er), 1); chk("mis_st_rdata", rd, 0); chk("mis_st_latency", lat, 3);
    do_req(0, 1'b0, 32'h10, 32'h0, 2'b00, 1'b0, rd, er, lat, bc);
    chk("ld_after_mis_st", rd, 32'hDEAD1234);
    do_req(0, 1'b0, 32'h12, 32'h0, 2'b11, 1'b0, rd, er, lat, bc);
    chk("size3_mis_err", 32'(er), 1); chk("size3_mis_rdata", rd, 0);
    do_req(0, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, rd, er, lat, bc);
    chk("size3_ld", rd, 32'hDEAD1234); chk("size3_err", 32'(er), 0);
    do_req(0, 1'b0, 32'h11, 32'h0, 2'b01, 1'b1, rd, er, lat, bc);
    chk("mis_half_err", 32'(er), 1); chk("mis_half_rdata", rd, 0);

    do_req(0, 1'b1, 32'h20, 32'h0, 2'b00, 1'b0, rd, er, lat, bc);
    @(negedge clk);
    req_write[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'hAAAAAAAA;
    req_size[0] = 2'b00; req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("wait_busy", 32'(busy[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_reset", 32'(req_ready[0]), 1);
    sawv = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (resp_valid[0]) sawv = 1'b1;
      @(negedge clk);
    end
    chk("no_resp_after_reset", 32'(sawv), 0);
    do_req(0, 1'b0, 32'h20, 32'h0, 2'b00, 1'b0, rd, er, lat, bc);
    chk("ld_after_aborted_st", rd, 32'h0);

    do_req(1, 1'b1, 32'h10, 32'h5A5AA5A5, 2'b00, 1'b0, rd, er, lat, bc);
    chk("w0_st_latency", lat, 1);
    req_write[1] = 1'b0; req_addr[1] = 32'h10 + 32'd4096; req_size[1] = 2'b00;
    req_signed[1] = 1'b0; req_valid[1] = 1'b1;
    na = 0; nr = 0; last_a = -1; last_r = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (resp_valid[1]) begin
        nr++;
        chk("b2b_alias_rdata", resp_rdata[1], 32'h5A5AA5A5);
        if (last_r >= 0) chk("b2b_resp_gap", cyc - last_r, 2);
        last_r = cyc;
      end
      if (req_ready[1]) begin
        na++;
        if (last_a >= 0) chk("b2b_accept_gap", cyc - last_a, 2);
        last_a = cyc;
      end
    end
    req_valid[1] = 1'b0;
    chk("b2b_accepts", na, 6);
    chk("b2b_responses", nr, 6);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
